alu_mc: RTL
===========

# alu_mc

Multi-cycle, parametrised successor to the execute-stage ALU, with a valid/ready handshake on both sides. Single-cycle operations (add, sub, logic, compares, address add) return after one cycle. MULT runs on an iterative shift-add engine; the new signed DIV/REM operations run on an iterative restoring divider. Sits between the issue stage and writeback, so the pipeline stalls on `in_ready` instead of depending on a combinational multiplier.

## Interface
- `WIDTH`, 32, operand/result width; must be even and ≥ 8.
- `MUL_BITS`, 1, multiplier bits retired per cycle; legal values 1, 2, 4; must divide `WIDTH`.
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — reset, synchronous, active-low.
- `in_valid` input 1 — operation offered.
- `in_ready` output 1 — operation accepted on a cycle where `in_valid && in_ready`.
- `opcode` input 7 — `[2:0]` type (`R_TYPE`/`I_TYPE`/other), `[6:3]` function (shared defines).
- `a`, `b` input WIDTH — operands.
- `out_valid` output 1 — result available.
- `out_ready` input 1 — consumer takes result on a cycle where `out_valid && out_ready`.
- `alu_out` output WIDTH — result.
- `alu_cc` output 4 — [3] divide-by-zero, [2] underflow/borrow, [1] signed overflow, [0] branch true.

## Operation
- The shared define file gains `DIV` = 4'hE and `REM` = 4'hF. These codes must not collide with existing codes.
- FSM states: IDLE, MUL, DIV, FIX, DONE. Operands and opcode are captured on accept.
- Types other than R/I: `alu_out` = a+b, with `alu_cc[1]` = signed add overflow; all other flags 0.
- All flags not named below for an operation are 0. `alu_out` is 0 for compares.
- Single-cycle operations go IDLE→DONE:
  - ADD: `[1]` = signed overflow.
  - SUB: `[1]` = signed overflow; `[2]` = ~carry-out of a + ~b + 1.
  - AND, OR, XOR, NOT (~a).
  - BEQ, BNE, BLT, BLE, BGT, BGE: signed compares using N^V and Z of a−b. The result goes in `[0]`.
- MULT: IDLE→MUL, then WIDTH/MUL_BITS iterations→DONE.
  - `alu_out` = low WIDTH bits of the signed product.
  - `[1]` = full signed 2·WIDTH product does not equal the sign extension of `alu_out`.
- DIV/REM: signed, truncated toward zero. Magnitudes are taken on accept.
  - IDLE→DIV runs WIDTH iterations→FIX; FIX applies signs→DONE.
  - Quotient sign = sign(a)^sign(b). Remainder sign = sign(a).
- Divide by zero (b=0): early-out IDLE→DONE.
  - DIV returns all-ones; REM returns a; `[3]`=1.
- Overflow case (a = most-negative, b = −1): early-out IDLE→DONE.
  - DIV returns most-negative; REM returns 0; `[1]`=1.
- DONE: outputs are held stable while `out_ready`=0. On a cycle with `out_ready`=1, go to IDLE, or straight into the next op if one is accepted that cycle.

## Timing
- Latency L is measured from the accept cycle to the first cycle with `out_valid`=1:
  - simple ops and early-outs: L=1.
  - MULT: L = WIDTH/MUL_BITS + 1.
  - DIV/REM: L = WIDTH + 2.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`). This is the only combinational path, `out_ready`→`in_ready`.
- Back-to-back simple ops with `out_ready`=1 sustain one result per cycle.
- Reset: on any edge with `rst_n`=0, the state goes to IDLE and any in-flight op is discarded.
  - Outputs after reset: `out_valid`=0, `alu_out`=0, `alu_cc`=0. `in_ready`=1 from the first cycle after reset releases.
- `out_valid` never drops without a handshake.
- `alu_out`/`alu_cc` do not change while `out_valid`=1 and `out_ready`=0.
- No op is accepted while MUL/DIV/FIX is busy.

## Test plan
- ADD 0x7FFFFFFF+1 (R_TYPE), `out_ready`=1 → next cycle `out_valid`=1, `alu_out`=0x80000000, `alu_cc`=4'b0010. Repeat SUB 0−1 → 0xFFFFFFFF, `alu_cc`=4'b0100.
- Compares with a=−5, b=3:
  - BLT → `alu_cc[0]`=1.
  - BGE → 0.
  - BEQ with a=b=7 → 1.
  - A stream of 4 back-to-back compares gives 4 consecutive `out_valid` cycles.
- MULT with MUL_BITS=1 and MUL_BITS=4:
  - a=−3, b=7 → `alu_out`=0xFFFFFFEB, `[1]`=0; `out_valid` at L=33 and L=9 respectively.
  - a=0x10000, b=0x10000 → `alu_out`=0, `[1]`=1.
- DIV/REM:
  - a=−7, b=2 → DIV −3, REM −1, L=34.
  - b=0 → DIV 0xFFFFFFFF, REM a, `[3]`=1, L=1.
  - a=0x80000000, b=−1 → DIV 0x80000000, `[1]`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after a DIV completes → `alu_out` stable, `in_ready`=0. Then raise `out_ready` with `in_valid` high → new op accepted in the same cycle.
- Drive `rst_n`=0 mid-MULT (iteration 10) → next cycle `out_valid`=0, `alu_cc`=0, `in_ready`=1. A following ADD 2+2 returns 4 with L=1.

Source files
------------

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Purpose  : Multi-cycle execute ALU with valid/ready on both sides.
//             Single-cycle ops, iterative shift-add MULT, restoring DIV/REM.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       alu_cc
);

    localparam logic [2:0] c_R_TYPE  = 3'b001;
    localparam logic [2:0] c_I_TYPE  = 3'b010;

    localparam logic [3:0] c_FN_ADD  = 4'h0;
    localparam logic [3:0] c_FN_SUB  = 4'h1;
    localparam logic [3:0] c_FN_AND  = 4'h2;
    localparam logic [3:0] c_FN_OR   = 4'h3;
    localparam logic [3:0] c_FN_XOR  = 4'h4;
    localparam logic [3:0] c_FN_NOT  = 4'h5;
    localparam logic [3:0] c_FN_BEQ  = 4'h6;
    localparam logic [3:0] c_FN_BNE  = 4'h7;
    localparam logic [3:0] c_FN_BLT  = 4'h8;
    localparam logic [3:0] c_FN_BLE  = 4'h9;
    localparam logic [3:0] c_FN_BGT  = 4'hA;
    localparam logic [3:0] c_FN_BGE  = 4'hB;
    localparam logic [3:0] c_FN_MULT = 4'hC;
    localparam logic [3:0] c_FN_DIV  = 4'hE;
    localparam logic [3:0] c_FN_REM  = 4'hF;

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_MUL  = 3'd1;
    localparam logic [2:0] c_S_DIV  = 3'd2;
    localparam logic [2:0] c_S_FIX  = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;

    localparam int c_MUL_ITER = WIDTH / MUL_BITS;
    localparam int c_CNT_W    = $clog2(WIDTH + 1);
    localparam int c_PW       = 2 * WIDTH;

    logic [2:0]         r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_alu_out;
    logic [3:0]         r_alu_cc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_PW-1:0]    r_acc;
    logic [c_PW-1:0]    r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_is_rem;

    logic [2:0]         w_ty;
    logic [3:0]         w_fn;
    logic               w_is_alu;
    logic               w_accept;
    logic [WIDTH-1:0]   w_sum;
    logic               w_add_ovf;
    logic [WIDTH:0]     w_sub_full;
    logic [WIDTH-1:0]   w_diff;
    logic               w_carry;
    logic               w_sub_ovf;
    logic               w_zero;
    logic               w_lt;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_b_zero;
    logic               w_div_ovf;
    logic [WIDTH-1:0]   w_res;
    logic [3:0]         w_cc;
    logic               w_go_mul;
    logic               w_go_div;
    logic [c_PW-1:0]    w_acc_init;
    logic [c_PW-1:0]    w_mul_part;
    logic [c_PW-1:0]    w_acc_next;
    logic               w_mul_ovf;
    logic [WIDTH:0]     w_rshift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;

    assign w_ty     = opcode[2:0];
    assign w_fn     = opcode[6:3];
    assign w_is_alu = (w_ty == c_R_TYPE) || (w_ty == c_I_TYPE);

    assign in_ready  = (r_state == c_S_IDLE) | ((r_state == c_S_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign alu_out   = r_alu_out;
    assign alu_cc    = r_alu_cc;

    assign w_sum      = a + b;
    assign w_add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_diff     = w_sub_full[WIDTH-1:0];
    assign w_carry    = w_sub_full[WIDTH];
    assign w_sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
    assign w_zero     = (w_diff == '0);
    assign w_lt       = w_diff[WIDTH-1] ^ w_sub_ovf;

    assign w_a_mag   = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_b_mag   = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign w_b_zero  = (b == '0);
    assign w_div_ovf = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    always_comb begin
        w_res    = w_sum;
        w_cc     = 4'b0000;
        w_go_mul = 1'b0;
        w_go_div = 1'b0;
        if (!w_is_alu) begin
            w_cc[1] = w_add_ovf;
        end else begin
            case (w_fn)
                c_FN_ADD: w_cc[1] = w_add_ovf;
                c_FN_SUB: begin
                    w_res   = w_diff;
                    w_cc[1] = w_sub_ovf;
                    w_cc[2] = ~w_carry;
                end
                c_FN_AND: w_res = a & b;
                c_FN_OR:  w_res = a | b;
                c_FN_XOR: w_res = a ^ b;
                c_FN_NOT: w_res = ~a;
                c_FN_BEQ: begin w_res = '0; w_cc[0] = w_zero;            end
                c_FN_BNE: begin w_res = '0; w_cc[0] = ~w_zero;           end
                c_FN_BLT: begin w_res = '0; w_cc[0] = w_lt;              end
                c_FN_BLE: begin w_res = '0; w_cc[0] = w_lt | w_zero;     end
                c_FN_BGT: begin w_res = '0; w_cc[0] = ~(w_lt | w_zero);  end
                c_FN_BGE: begin w_res = '0; w_cc[0] = ~w_lt;             end
                c_FN_MULT: w_go_mul = 1'b1;
                c_FN_DIV, c_FN_REM: begin
                    // zero divisor and MIN/-1 resolve immediately, never enter the divider
                    if (w_b_zero) begin
                        w_res   = (w_fn == c_FN_DIV) ? {WIDTH{1'b1}} : a;
                        w_cc[3] = 1'b1;
                    end else if (w_div_ovf) begin
                        w_res   = (w_fn == c_FN_DIV) ? a : '0;
                        w_cc[1] = 1'b1;
                    end else begin
                        w_go_div = 1'b1;
                    end
                end
                default: w_res = w_sum;  // address add: plain sum, no flags
            endcase
        end
    end

    // b is consumed as unsigned; pre-loading -(a << WIDTH) corrects for a negative b
    assign w_acc_init = b[WIDTH-1] ? ({c_PW{1'b0}} - {a, {WIDTH{1'b0}}}) : {c_PW{1'b0}};

    always_comb begin
        w_mul_part = '0;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (r_mplier[j]) begin
                w_mul_part = w_mul_part + (r_mcand << j);
            end
        end
    end

    assign w_acc_next = r_acc + w_mul_part;
    assign w_mul_ovf  = (w_acc_next[c_PW-1:WIDTH] != {WIDTH{w_acc_next[WIDTH-1]}});

    assign w_rshift   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_rshift >= {1'b0, r_dvsr});
    assign w_rem_next = w_ge ? WIDTH'(w_rshift - {1'b0, r_dvsr}) : w_rshift[WIDTH-1:0];

    assign w_quo_s = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_s = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_alu_cc    <= 4'b0000;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                c_S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << MUL_BITS;
                    r_mplier <= r_mplier >> MUL_BITS;
                    if (r_cnt == '0) begin
                        r_state     <= c_S_DONE;
                        r_out_valid <= 1'b1;
                        r_alu_out   <= w_acc_next[WIDTH-1:0];
                        r_alu_cc    <= {2'b00, w_mul_ovf, 1'b0};
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= c_S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_S_FIX: begin
                    r_state     <= c_S_DONE;
                    r_out_valid <= 1'b1;
                    r_alu_out   <= r_is_rem ? w_rem_s : w_quo_s;
                    r_alu_cc    <= 4'b0000;
                end
                c_S_IDLE, c_S_DONE: begin
                    if ((r_state == c_S_DONE) && out_ready) begin
                        r_state     <= c_S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        r_mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
                        r_mplier <= b;
                        r_acc    <= w_acc_init;
                        r_rem    <= '0;
                        r_quo    <= w_a_mag;
                        r_dvsr   <= w_b_mag;
                        r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_r  <= a[WIDTH-1];
                        r_is_rem <= (w_fn == c_FN_REM);
                        if (w_go_mul) begin
                            r_state <= c_S_MUL;
                            r_cnt   <= c_CNT_W'(c_MUL_ITER - 1);
                        end else if (w_go_div) begin
                            r_state <= c_S_DIV;
                            r_cnt   <= c_CNT_W'(WIDTH - 1);
                        end else begin
                            r_state     <= c_S_DONE;
                            r_out_valid <= 1'b1;
                            r_alu_out   <= w_res;
                            r_alu_cc    <= w_cc;
                        end
                    end
                end
                default: begin
                    r_state     <= c_S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
